// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle for the LDM/STM sequencer.
//   op request   : i_start, i_is_load, i_pre, i_up, i_wback, i_base_code,
//                  i_base_reg, i_reg_list
//   reg read     : o_re_code -> i_re_reg
//   memory       : o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata <- i_mem_ack, i_mem_rdata
//   load write   : o_rd_en, o_rd_code, o_rd_reg
//   base wback   : o_wb_en, o_wb_code, o_wb_reg
//   status       : o_busy, o_done
// The sequencer connects through modport master; the pipeline/memory side uses slave.
interface ldm_stm_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int LIST_W = 16
);
  logic              i_start;
  logic              i_is_load;
  logic              i_pre;
  logic              i_up;
  logic              i_wback;
  logic [3:0]        i_base_code;
  logic [DATA_W-1:0] i_base_reg;
  logic [LIST_W-1:0] i_reg_list;
  logic [3:0]        o_re_code;
  logic [DATA_W-1:0] i_re_reg;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_rd_en;
  logic [3:0]        o_rd_code;
  logic [DATA_W-1:0] o_rd_reg;
  logic              o_wb_en;
  logic [3:0]        o_wb_code;
  logic [DATA_W-1:0] o_wb_reg;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_is_load, i_pre, i_up, i_wback, i_base_code, i_base_reg,
           i_reg_list, i_re_reg, i_mem_ack, i_mem_rdata,
    output o_re_code, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rd_en, o_rd_code, o_rd_reg, o_wb_en, o_wb_code, o_wb_reg,
           o_busy, o_done
  );

  modport slave (
    output i_start, i_is_load, i_pre, i_up, i_wback, i_base_code, i_base_reg,
           i_reg_list, i_re_reg, i_mem_ack, i_mem_rdata,
    input  o_re_code, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
           o_rd_en, o_rd_code, o_rd_reg, o_wb_en, o_wb_code, o_wb_reg,
           o_busy, o_done
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Multi-cycle LDM/STM controller. Latches one block-transfer op, walks the
// register list lowest-first issuing one word access per register, then
// writes back the base register and pulses o_done.
// Ports: clk, rst_n (async, active low), en (0 freezes all state),
//        bus (ldm_stm_sequencer_if.master: op request, reg read, memory,
//        load write port, base writeback, busy/done).
module ldm_stm_sequencer #(
  parameter int DATA_W = 32,
  parameter int LIST_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  ldm_stm_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(LIST_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WBACK, S_DONE} state_t;

  typedef struct packed {
    logic              load;
    logic              pre;
    logic              up;
    logic              wback;
    logic              base_in_list;
    logic [3:0]        base_code;
    logic [DATA_W-1:0] base;
  } op_t;

  state_t            r_state, w_next;
  op_t               r_op;
  logic [LIST_W-1:0] r_list;
  logic [DATA_W-1:0] r_addr, r_new_base;

  logic [CNT_W-1:0]  w_cnt;
  logic [DATA_W-1:0] w_step, w_lo, w_first_addr, w_new_base;
  logic [LIST_W-1:0] w_bit;
  logic [3:0]        w_code;
  logic              w_last;

  function automatic logic [CNT_W-1:0] popcnt(input logic [LIST_W-1:0] l);
    popcnt = '0;
    for (int k = 0; k < LIST_W; k++) popcnt = popcnt + CNT_W'(l[k]);
  endfunction

  function automatic logic [3:0] lowest(input logic [LIST_W-1:0] l);
    lowest = '0;
    for (int k = LIST_W - 1; k >= 0; k--) if (l[k]) lowest = 4'(k);
  endfunction

  // Block spans [lo, lo+4n). Addresses always ascend; the P/U combination
  // only decides where the span sits and whether the first word is skipped.
  assign w_cnt        = popcnt(r_list);
  assign w_step       = DATA_W'(w_cnt) << 2;
  assign w_lo         = r_op.up ? r_op.base : r_op.base - w_step;
  assign w_first_addr = w_lo + ((r_op.pre == r_op.up) ? DATA_W'(4) : DATA_W'(0));
  assign w_new_base   = r_op.up ? r_op.base + w_step : r_op.base - w_step;

  assign w_bit  = r_list & (~r_list + LIST_W'(1));
  assign w_code = lowest(r_list);
  assign w_last = (r_list & ~w_bit) == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_list     <= '0;
      r_addr     <= '0;
      r_new_base <= '0;
    end else if (en) begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_op.load         <= bus.i_is_load;
          r_op.pre          <= bus.i_pre;
          r_op.up           <= bus.i_up;
          r_op.wback        <= bus.i_wback;
          r_op.base_in_list <= bus.i_reg_list[bus.i_base_code];
          r_op.base_code    <= bus.i_base_code;
          r_op.base         <= bus.i_base_reg;
          r_list            <= bus.i_reg_list;
        end
        S_SETUP: begin
          r_addr     <= w_first_addr;
          r_new_base <= w_new_base;
        end
        S_XFER: if (bus.i_mem_ack) begin
          r_list <= r_list & ~w_bit;
          r_addr <= r_addr + DATA_W'(4);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_SETUP;
      S_SETUP: w_next = (r_list == '0) ? S_DONE : S_XFER;
      S_XFER:  if (bus.i_mem_ack && w_last) w_next = S_WBACK;
      S_WBACK: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_re_code   = '0;
    bus.o_mem_req   = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = bus.i_re_reg;
    bus.o_rd_en     = 1'b0;
    bus.o_rd_code   = '0;
    bus.o_rd_reg    = '0;
    bus.o_wb_en     = 1'b0;
    bus.o_wb_code   = r_op.base_code;
    bus.o_wb_reg    = r_new_base;
    bus.o_busy      = (r_state == S_SETUP) || (r_state == S_XFER) || (r_state == S_WBACK);
    bus.o_done      = (r_state == S_DONE);
    if (r_state == S_XFER) begin
      bus.o_re_code  = w_code;
      bus.o_mem_req  = 1'b1;
      bus.o_mem_we   = ~r_op.load;
      bus.o_mem_addr = r_addr;
      // An ack during a freeze is not consumed, so no register write either.
      if (bus.i_mem_ack && en && r_op.load) begin
        bus.o_rd_en   = 1'b1;
        bus.o_rd_code = w_code;
        bus.o_rd_reg  = bus.i_mem_rdata;
      end
    end
    // A base register that was itself loaded keeps the loaded value.
    if (r_state == S_WBACK)
      bus.o_wb_en = r_op.wback && !(r_op.load && r_op.base_in_list);
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;
  logic clk = 1'b0;
  logic rst_n, en;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer_if #(.DATA_W(32), .LIST_W(16)) bus();
  ldm_stm_sequencer #(.DATA_W(32), .LIST_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, bus.o_mem_req, 0);
    chk({tag, "_addr"}, bus.o_mem_addr, 0);
    chk({tag, "_rd_en"}, bus.o_rd_en, 0);
    chk({tag, "_re_code"}, bus.o_re_code, 0);
    chk({tag, "_wb_en"}, bus.o_wb_en, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_done"}, bus.o_done, 0);
  endtask

  // Reference: a transfer is the ascending list of listed registers placed
  // on a contiguous word block; the timeline is start, setup, one step per
  // access (plus wait states), writeback (if any access), done.
  task automatic run_op(input bit load, pre, up, wb, input logic [3:0] bc,
                        input logic [31:0] base, input logic [15:0] list,
                        input int maxd, input int freeze_at);
    int          codes[$];
    int          n, d;
    logic [31:0] addr0, nbase, rdat, rreg;
    bit          exp_wb;
    for (int k = 0; k < 16; k++) if (list[k]) codes.push_back(k);
    n = codes.size();
    if (!up)      addr0 = base - 32'(4 * n) + (pre ? 32'd0 : 32'd4);
    else          addr0 = base + (pre ? 32'd4 : 32'd0);
    nbase  = up ? base + 32'(4 * n) : base - 32'(4 * n);
    exp_wb = wb && !(load && list[bc]);

    @(negedge clk);
    en = 1; bus.i_mem_ack = 0;
    bus.i_start = 1; bus.i_is_load = load; bus.i_pre = pre; bus.i_up = up;
    bus.i_wback = wb; bus.i_base_code = bc; bus.i_base_reg = base; bus.i_reg_list = list;
    #1 chk("idle_busy", bus.o_busy, 0);
    chk("idle_req", bus.o_mem_req, 0);

    @(negedge clk);
    bus.i_start = 0; bus.i_base_reg = $urandom; bus.i_reg_list = 16'($urandom);
    bus.i_is_load = ~load; bus.i_base_code = 4'($urandom);
    #1 chk("setup_busy", bus.o_busy, 1);
    chk("setup_req", bus.o_mem_req, 0);

    for (int i = 0; i < n; i++) begin
      if (i == freeze_at) begin
        repeat (2) begin
          @(negedge clk);
          en = 0; bus.i_mem_ack = 1; bus.i_mem_rdata = $urandom;
          #1 chk("frz_req", bus.o_mem_req, 1);
          chk("frz_addr", bus.o_mem_addr, addr0 + 32'(4 * i));
          chk("frz_rd_en", bus.o_rd_en, 0);
        end
      end
      d = $urandom_range(maxd, 0);
      for (int j = 0; j <= d; j++) begin
        @(negedge clk);
        en = 1;
        bus.i_mem_ack = (j == d);
        rdat = $urandom; rreg = $urandom;
        bus.i_mem_rdata = rdat; bus.i_re_reg = rreg;
        #1 chk("xfer_req", bus.o_mem_req, 1);
        chk("xfer_addr", bus.o_mem_addr, addr0 + 32'(4 * i));
        chk("xfer_code", bus.o_re_code, 32'(codes[i]));
        chk("xfer_we", bus.o_mem_we, !load);
        chk("xfer_busy", bus.o_busy, 1);
        chk("xfer_rd_en", bus.o_rd_en, (j == d) && load);
        if (j == d && load) begin
          chk("xfer_rd_code", bus.o_rd_code, 32'(codes[i]));
          chk("xfer_rd_reg", bus.o_rd_reg, rdat);
        end
        if (!load) chk("xfer_wdata", bus.o_mem_wdata, rreg);
      end
    end

    if (n > 0) begin
      @(negedge clk);
      bus.i_mem_ack = 0;
      #1 chk("wb_en", bus.o_wb_en, exp_wb);
      chk("wb_busy", bus.o_busy, 1);
      chk("wb_req", bus.o_mem_req, 0);
      if (exp_wb) begin
        chk("wb_code", bus.o_wb_code, 32'(bc));
        chk("wb_reg", bus.o_wb_reg, nbase);
      end
    end

    @(negedge clk);
    bus.i_mem_ack = 0;
    #1 chk("done", bus.o_done, 1);
    chk("done_busy", bus.o_busy, 0);
    chk("done_wb_en", bus.o_wb_en, 0);
    chk("done_req", bus.o_mem_req, 0);

    @(negedge clk);
    #1 chk("post_done", bus.o_done, 0);
    chk("post_busy", bus.o_busy, 0);
  endtask

  initial begin
    rst_n = 0; en = 1;
    bus.i_start = 0; bus.i_is_load = 0; bus.i_pre = 0; bus.i_up = 0; bus.i_wback = 0;
    bus.i_base_code = 0; bus.i_base_reg = 0; bus.i_reg_list = 0;
    bus.i_re_reg = 0; bus.i_mem_ack = 0; bus.i_mem_rdata = 0;
    #12 chk_quiet("reset");
    @(negedge clk); rst_n = 1;

    // LDMIA r0!,{r1,r2,r4}
    run_op(1, 0, 1, 1, 4'd0, 32'h1000, 16'h0016, 0, -1);
    // STMDB r13!,{r4,r14}
    run_op(0, 1, 0, 1, 4'd13, 32'h2000, 16'h4010, 0, -1);
    // LDMIB r0,{r3} with 3 wait states
    run_op(1, 1, 1, 0, 4'd0, 32'h1000, 16'h0008, 0, -1);
    run_op(1, 1, 1, 0, 4'd0, 32'h1000, 16'h0008, 3, -1);
    // empty list, W=1
    run_op(1, 0, 1, 1, 4'd5, 32'h3000, 16'h0000, 0, -1);
    // LDMIA r2!,{r1,r2}: loaded base wins
    run_op(1, 0, 1, 1, 4'd2, 32'h0400, 16'h0006, 0, -1);
    // STMDA with base in list still writes back; R15 load; address wrap
    run_op(0, 0, 0, 1, 4'd3, 32'h0000_0008, 16'hFFFF, 1, 2);
    run_op(1, 0, 1, 1, 4'd1, 32'hFFFF_FFF8, 16'h8001, 0, 1);

    // async reset during the second access
    @(negedge clk);
    bus.i_start = 1; bus.i_is_load = 1; bus.i_pre = 0; bus.i_up = 1; bus.i_wback = 1;
    bus.i_base_code = 0; bus.i_base_reg = 32'h5000; bus.i_reg_list = 16'h000E;
    @(negedge clk); bus.i_start = 0;
    @(negedge clk); bus.i_mem_ack = 1;
    @(negedge clk); bus.i_mem_ack = 0;
    #1 chk("pre_rst_addr", bus.o_mem_addr, 32'h5004);
    rst_n = 0;
    #1 chk_quiet("mid_rst");
    @(negedge clk); rst_n = 1;
    run_op(0, 1, 1, 1, 4'd9, 32'h6000, 16'h0300, 1, -1);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] l;
      l = 16'($urandom) & 16'($urandom);
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
             $urandom & 32'hFFFF_FFFC, l, $urandom_range(3, 0),
             ($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
